button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
Upstream conditioning stage for push-button inputs. It synchronises the raw asynchronous pad signal into clk, then filters contact bounce with a counter-qualified four-state FSM. It produces a clean registered level plus one-cycle rise/fall strobes. btn_level feeds the existing edge-to-pulse button stage directly; btn_rise/btn_fall serve consumers that need strobes without it.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on btn_in; legal range >= 2.
DEBOUNCE_CYCLES, 1000000, consecutive extra stable samples required to accept a change (10 ms at 100 MHz); legal range >= 2.
CNT_W, $clog2(DEBOUNCE_CYCLES), derived local width of the stability counter; not user-overridable.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset; asynchronous, active-high.
btn_in  input  1  raw button pad signal, asynchronous to clk, active-high.
btn_level  output  1  debounced level, registered.
btn_rise  output  1  one-cycle strobe when btn_level goes 0->1.
btn_fall  output  1  one-cycle strobe when btn_level goes 1->0.
busy  output  1  high while a candidate transition is being qualified (CHK_HI/CHK_LO).

Behaviour:
- Reset (rst=1, asynchronous assert):
  - all sync flops, state, counter and outputs clear immediately.
  - state=STABLE_LO; btn_level=0, btn_rise=0, btn_fall=0, busy=0, regardless of btn_in.
- Synchroniser: SYNC_STAGES flops in series; the last stage is btn_s. The FSM reads only btn_s.
- States: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
- STABLE_LO: btn_s=1 -> CHK_HI, cnt<=0. Otherwise hold.
- CHK_HI, per edge:
  - btn_s=0 -> STABLE_LO (abort), cnt<=0, no strobe.
  - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, btn_level<=1, btn_rise<=1 for exactly one cycle.
  - otherwise cnt<=cnt+1.
- STABLE_HI / CHK_LO: mirror of the above with polarity inverted. Acceptance sets btn_level<=0 and pulses btn_fall.
- Acceptance rule: a change is accepted only after DEBOUNCE_CYCLES+1 consecutive equal btn_s samples (entry edge plus DEBOUNCE_CYCLES counted edges).
- Latency: btn_in held steady -> btn_level changes SYNC_STAGES+1+DEBOUNCE_CYCLES edges after the first edge that samples the new value.
  - Strobe is high in the first cycle that btn_level shows the new value.
- busy is high exactly while in CHK_HI/CHK_LO: DEBOUNCE_CYCLES cycles for an accepted change, fewer on abort.
- Counter:
  - unsigned, CNT_W bits; never exceeds DEBOUNCE_CYCLES-1, so no wrap-around.
  - cleared on every STABLE->CHK entry and every abort.
- Strobe rules:
  - btn_rise and btn_fall are never high together and never high on consecutive cycles.
  - minimum spacing between strobes is DEBOUNCE_CYCLES+1 cycles.
- Glitches: any btn_s excursion of <= DEBOUNCE_CYCLES samples produces no change on btn_level or the strobes.
- Reset mid-qualification: progress is discarded.
  - After release with btn_in still high, the full latency applies again from the first sample.
  - btn_rise fires once, after qualification completes.
- Unused state encodings -> STABLE_LO on the next edge, outputs 0.
- All outputs are registered; no combinational path from btn_in to any output.

Decomposition:
- Shared package (button_pkg): state encoding localparams STABLE_LO=2'd0, CHK_HI=2'd1, STABLE_HI=2'd2, CHK_LO=2'd3; default DEBOUNCE_CYCLES constant.
- Sub-module button_sync_ff: parameterised SYNC_STAGES flop chain with async active-high reset to 0. Reusable for other pad inputs.
- FSM, counter and output registers live in button_debounce.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=8, so expected latency is 11 edges.
1. Hold rst=1 with btn_in=1 -> all outputs 0. Release rst -> btn_level=1 and one-cycle btn_rise 11 edges later; busy high for 8 cycles before that.
2. btn_in 0->1 held 30 cycles -> btn_rise single cycle at edge 11; btn_level stays 1; btn_fall never asserts.
3. Boundary: btn_in high 8 cycles then low -> no btn_rise, btn_level stays 0. Repeat with 9 cycles high -> btn_rise at edge 11, then btn_fall 11 edges after the fall.
4. Bounce train: 4x (high 5 cycles, low 3 cycles), then steady high -> no output activity during the train; one btn_rise 11 edges after the final rising edge.
5. In STABLE_HI, btn_in low for 1 cycle -> no btn_fall, busy pulses and clears. Then hold low -> btn_fall at edge 11, btn_level=0.
6. During CHK_HI with cnt=5, pulse rst for 1 cycle with btn_in held high -> outputs 0 immediately, no strobe. Full 11-edge latency restarts after release; exactly one btn_rise.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioning path.
// State encodings and default qualification length.
package button_pkg;

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] CHK_HI    = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] CHK_LO    = 2'd3;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  function automatic logic is_chk(input logic [1:0] s);
    return (s == CHK_HI) || (s == CHK_LO);
  endfunction

endpackage

// File: rtl/button_sync_ff.sv
// Multi-flop synchroniser for an asynchronous pad input.
// Resets every stage to 0; o_q is the last stage.
module button_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  // shift the pad value through the chain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_q <= '0;
    else       r_q <= {r_q[STAGES-2:0], i_d};
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchroniser plus counter-qualified FSM.
// Emits a registered level and one-cycle rise/fall strobes.
module button_debounce
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_btn_s;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;
  logic             r_busy;

  button_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (btn_in),
    .o_q   (w_btn_s)
  );

  // next-state, counter and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      STABLE_LO: begin
        w_level_nxt = 1'b0;
        if (w_btn_s) begin
          w_state_nxt = CHK_HI;
          w_cnt_nxt   = '0;
        end
      end
      CHK_HI: begin
        if (!w_btn_s) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        w_level_nxt = 1'b1;
        if (!w_btn_s) begin
          w_state_nxt = CHK_LO;
          w_cnt_nxt   = '0;
        end
      end
      CHK_LO: begin
        if (w_btn_s) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  // state, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= is_chk(w_state_nxt);
    end
  end

  assign btn_level = r_level;
  assign btn_rise  = r_rise;
  assign btn_fall  = r_fall;
  assign busy      = r_busy;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce.
// SYNC_STAGES=2, DEBOUNCE_CYCLES=8: 11-edge latency.
module tb_button_debounce;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic busy;

  int checks;
  int failures;

  int edge_no;
  int rise_n;
  int fall_n;
  int rise_at;
  int fall_at;
  int busy_n;
  int viol_n;
  logic prev_strobe;

  button_debounce #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    edge_no = 0;
    rise_n  = 0;
    fall_n  = 0;
    rise_at = -1;
    fall_at = -1;
    busy_n  = 0;
  endtask

  // advance one edge and sample 1 ns after it
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_no++;
      if (btn_rise) begin
        rise_n++;
        rise_at = edge_no;
      end
      if (btn_fall) begin
        fall_n++;
        fall_at = edge_no;
      end
      if (busy) busy_n++;
      if (btn_rise && btn_fall) viol_n++;
      if ((btn_rise || btn_fall) && prev_strobe) viol_n++;
      prev_strobe = btn_rise || btn_fall;
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    viol_n      = 0;
    prev_strobe = 1'b0;
    clr_stats();

    // 1: reset with button held, then release
    rst    = 1'b1;
    btn_in = 1'b1;
    tick(4);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_rise",  int'(btn_rise),  0);
    chk("rst_fall",  int'(btn_fall),  0);
    chk("rst_busy",  int'(busy),      0);
    rst = 1'b0;
    clr_stats();
    tick(20);
    chk("s1_rise_n",  rise_n,  1);
    chk("s1_rise_at", rise_at, 11);
    chk("s1_busy_n",  busy_n,  8);
    chk("s1_level",   int'(btn_level), 1);

    // release to get back to low
    btn_in = 1'b0;
    clr_stats();
    tick(20);
    chk("s1_fall_at", fall_at, 11);
    chk("s1_lvl0",    int'(btn_level), 0);

    // 2: clean press held 30 cycles
    btn_in = 1'b1;
    clr_stats();
    tick(30);
    chk("s2_rise_n",  rise_n,  1);
    chk("s2_rise_at", rise_at, 11);
    chk("s2_fall_n",  fall_n,  0);
    chk("s2_level",   int'(btn_level), 1);
    btn_in = 1'b0;
    tick(20);

    // 3a: 8-cycle pulse is rejected
    clr_stats();
    btn_in = 1'b1;
    tick(8);
    btn_in = 1'b0;
    tick(25);
    chk("s3a_rise_n", rise_n, 0);
    chk("s3a_busy_n", busy_n, 8);
    chk("s3a_level",  int'(btn_level), 0);

    // 3b: 9-cycle pulse is accepted
    clr_stats();
    btn_in = 1'b1;
    tick(9);
    btn_in = 1'b0;
    tick(25);
    chk("s3b_rise_n",  rise_n,  1);
    chk("s3b_rise_at", rise_at, 11);
    chk("s3b_fall_n",  fall_n,  1);
    chk("s3b_fall_at", fall_at, 20);
    chk("s3b_level",   int'(btn_level), 0);

    // 4: bounce train then steady high
    clr_stats();
    for (int k = 0; k < 4; k++) begin
      btn_in = 1'b1;
      tick(5);
      btn_in = 1'b0;
      tick(3);
    end
    chk("s4_train_str",
        rise_n + fall_n, 0);
    chk("s4_train_lvl", int'(btn_level), 0);
    clr_stats();
    btn_in = 1'b1;
    tick(20);
    chk("s4_rise_n",  rise_n,  1);
    chk("s4_rise_at", rise_at, 11);
    chk("s4_level",   int'(btn_level), 1);

    // 5: single-cycle dropout in STABLE_HI
    clr_stats();
    btn_in = 1'b0;
    tick(1);
    btn_in = 1'b1;
    tick(20);
    chk("s5_glitch_fall", fall_n, 0);
    chk("s5_glitch_busy", busy_n, 1);
    chk("s5_busy_end",    int'(busy), 0);
    chk("s5_glitch_lvl",  int'(btn_level), 1);
    clr_stats();
    btn_in = 1'b0;
    tick(20);
    chk("s5_fall_n",  fall_n,  1);
    chk("s5_fall_at", fall_at, 11);
    chk("s5_level",   int'(btn_level), 0);

    // 6: reset pulse during CHK_HI at cnt=5
    clr_stats();
    btn_in = 1'b1;
    tick(8);
    chk("s6_busy_pre", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_busy",  int'(busy),      0);
    chk("s6_rst_level", int'(btn_level), 0);
    chk("s6_rst_rise",  int'(btn_rise),  0);
    tick(1);
    rst = 1'b0;
    chk("s6_pre_rise", rise_n, 0);
    clr_stats();
    tick(25);
    chk("s6_rise_n",  rise_n,  1);
    chk("s6_rise_at", rise_at, 11);
    chk("s6_level",   int'(btn_level), 1);

    chk("strobe_rules", viol_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
